// File: rtl/wisc_alu_pkg.sv
// ---------------------------------------------------------------------------
// wisc_alu_pkg
// Shared definitions for the WISC ALU datapath blocks.
//   state_t   : FSM encoding for the multi-cycle add/subtract unit
//   NIBBLE_W  : slice width handled by the shared nibble adder
//   sat_pos() : most positive two's-complement value of a given width
//   sat_neg() : most negative two's-complement value of a given width
// The saturation helpers return a 64-bit value; callers truncate to width.
// ---------------------------------------------------------------------------
package wisc_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // 0 followed by (width-1) ones
  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // 1 followed by (width-1) zeros
  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fulladder_4bit.sv
// ---------------------------------------------------------------------------
// fulladder_4bit
// Purely combinational 4-bit ripple-carry adder used as the shared nibble
// datapath of the sequential add/subtract unit.
// Ports:
//   a, b  : 4-bit operand nibbles
//   cin   : carry in
//   sum   : 4-bit sum nibble
//   cout  : carry out of the top bit
// ---------------------------------------------------------------------------
module fulladder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carries rippling upward
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[4];

endmodule

// File: rtl/addsub_16bit_seq.sv
// ---------------------------------------------------------------------------
// addsub_16bit_seq
// Multi-cycle signed add/subtract unit. A single 4-bit nibble adder is reused
// over WIDTH/4 cycles, least significant nibble first, with the carry held in
// a register between cycles. Subtraction is A + ~B + 1 (carry seeded with 1).
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, accepted only in IDLE or DONE
//   sub   : 0 = A+B, 1 = A-B (sampled with start)
//   A, B  : signed operands (sampled with start)
//   busy  : high while the nibble cycles are running
//   done  : one-cycle pulse when Sum/Ovfl are valid
//   Sum   : registered result, held until the next accepted operation runs
//   Ovfl  : registered two's-complement overflow flag
// Configuration macro:
//   ADD_SAT_EN : when defined, an overflowing result is replaced by the
//                saturated value (most positive / most negative).
// ---------------------------------------------------------------------------
module addsub_16bit_seq
  import wisc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

`ifdef ADD_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

  state_t              state;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic                c;
  logic [KW-1:0]       k;

  logic                accept;
  logic                last;
  int                  base;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                ovf_last;
  logic [WIDTH-1:0]    next_sum;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (k == KW'(N - 1));
  assign base   = int'(k) * NIBBLE_W;

  // Operand slice selection for the current nibble
  always_comb begin
    a_nib = a_r[base +: NIBBLE_W];
    b_nib = b_r[base +: NIBBLE_W];
  end

  fulladder_4bit u_nibble (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Overflow uses the already-inverted B operand, so the same rule covers
  // both add and subtract; only meaningful on the last nibble.
  always_comb begin
    ovf_last = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
               (nib_sum[NIBBLE_W-1] != a_r[WIDTH-1]);
    next_sum = Sum;
    next_sum[base +: NIBBLE_W] = nib_sum;
`ifdef ADD_SAT_EN
    // Overflow direction follows the sign both operands share
    if (last && ovf_last) begin
      next_sum = a_r[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
`endif
  end

  // Control FSM, counter, carry register and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Ovfl  <= 1'b0;
      k     <= '0;
      c     <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end
        RUN: begin
          Sum <= next_sum;
          c   <= nib_cout;
          if (last) begin
            Ovfl  <= ovf_last;
            k     <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      // Accepting a new operation overrides the IDLE/DONE next-state above
      if (accept) begin
        a_r   <= A;
        b_r   <= sub ? ~B : B;
        c     <= sub;
        k     <= '0;
        Ovfl  <= 1'b0;
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_16bit_seq.sv
// ---------------------------------------------------------------------------
// tb_addsub_16bit_seq
// Self-checking bench for addsub_16bit_seq: a vector table with expected
// results (wrap and saturating variants, selected by ADD_SAT_EN), plus
// hand-written back-to-back, busy-ignore and mid-operation reset sequences.
// Expected results go into a scoreboard queue when an operation is started
// and are compared whenever the unit pulses done.
// ---------------------------------------------------------------------------
module tb_addsub_16bit_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] expWrap;
    logic [15:0] expSat;
    logic        expOvfl;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [15:0] Sum;
  logic        Ovfl;

  int   assertCount = 0;
  int   failCount   = 0;
  exp_t scoreQ[$];

  addsub_16bit_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Ovfl  (Ovfl)
  );

  always #5 clk = ~clk;

  // Generic comparison with pass/fail accounting
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      assertCount++;
      if (busy && done) begin
        failCount++;
        $display("[TB] FAIL busy_done_overlap: busy=%0b done=%0b at %0t", busy, done, $time);
      end
      if (done) begin
        if (scoreQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_done: Sum=0x%0h with no pending operation at %0t", Sum, $time);
        end else begin
          exp_t e;
          e = scoreQ.pop_front();
          checkVal("sb_sum", {16'd0, Sum}, {16'd0, e.sum});
          checkVal("sb_ovfl", {31'd0, Ovfl}, {31'd0, e.ovfl});
        end
      end
    end
  end

  // Drive one start pulse and record its expected result
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                               input logic [15:0] expSum, input logic expOvfl);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    sub = s;
    start = 1'b1;
    e.sum = expSum;
    e.ovfl = expOvfl;
    scoreQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checkVal("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done, check latency, pulse width and result hold
  task automatic checkOutput(input int expLat, input logic [15:0] expSum);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1;
        break;
      end
    end
    checkVal("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      checkVal("done_latency", lat, expLat);
      @(negedge clk);
      checkVal("done_one_cycle", {31'd0, done}, 32'd0);
      checkVal("sum_held", {16'd0, Sum}, {16'd0, expSum});
    end
  endtask

  vec_t vecs[12];

  initial begin
    int seen;
    int cyc;
    int lastCyc;
    logic [15:0] exp16;

    vecs[0]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1};
    vecs[5]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
    vecs[6]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 16'hBE01, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b0};
    vecs[11] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 16'h7FFF, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("reset_busy", {31'd0, busy}, 32'd0);
    checkVal("reset_done", {31'd0, done}, 32'd0);
    checkVal("reset_sum", {16'd0, Sum}, 32'd0);
    checkVal("reset_ovfl", {31'd0, Ovfl}, 32'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
`ifdef ADD_SAT_EN
      exp16 = vecs[i].expSat;
`else
      exp16 = vecs[i].expWrap;
`endif
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, exp16, vecs[i].expOvfl);
      checkOutput(4, exp16);
    end

    // Back-to-back: start held high, three results one every 5 cycles
    @(negedge clk);
    A = 16'h0F0F;
    B = 16'h00F1;
    sub = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) scoreQ.push_back('{16'h1000, 1'b0});
    seen = 0;
    cyc = 0;
    lastCyc = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen++;
        if (seen > 1) checkVal("b2b_interval", cyc - lastCyc, 5);
        lastCyc = cyc;
        if (seen == 3) start = 1'b0;
      end
    end
    checkVal("b2b_count", seen, 3);
    repeat (8) @(negedge clk);

    // Operands and start changed mid-RUN must be ignored
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    A = 16'hFFFF;
    B = 16'hFFFF;
    sub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput(3, 16'h1000);
    repeat (8) @(negedge clk);

    // Reset during the 2nd RUN cycle aborts without a done
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("abort_busy", {31'd0, busy}, 32'd0);
    checkVal("abort_done", {31'd0, done}, 32'd0);
    checkVal("abort_sum", {16'd0, Sum}, 32'd0);
    checkVal("abort_ovfl", {31'd0, Ovfl}, 32'd0);
    scoreQ.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("abort_no_done", {31'd0, done}, 32'd0);
    end
    applyStimulus(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);
    checkOutput(4, 16'h0005);

    repeat (3) @(negedge clk);
    checkVal("scoreboard_empty", scoreQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/addsub_16bit_seq.md
# addsub_16bit_seq

Multi-cycle 16-bit signed add/subtract unit for the WISC ALU datapath. It time-multiplexes a single 4-bit nibble adder (fulladder_4bit) over four cycles. The unit feeds the nibble adder its operand slices and carry, and collects its sum nibbles and carry-out into a result register. It is used where area matters more than latency and is driven by the ALU control through a start/done handshake.

## Interface
- WIDTH, default 16: operand width; must be a multiple of 4. Nibble count N = WIDTH/4.
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- start  input  1  request; sampled only when the unit can accept (IDLE or DONE)
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- A  input  WIDTH  signed operand, sampled with start
- B  input  WIDTH  signed operand, sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when Sum/Ovfl become valid
- Sum  output  WIDTH  registered result; held until the next accepted start
- Ovfl  output  1  registered two's-complement overflow flag for the last operation

## Operation
- States:
  - IDLE → RUN on start.
  - RUN stays in RUN while the nibble counter is below N−1, then → DONE.
  - DONE → RUN on start, otherwise → IDLE.
- Accept (start in IDLE or DONE):
  - Latch A_r = A.
  - Latch B_r = sub ? ~B : B.
  - Set carry register c = sub.
  - Clear the nibble counter k.
  - Clear Ovfl. Sum is not cleared.
- In RUN, each cycle:
  - The adder receives A_r[4k+3:4k], B_r[4k+3:4k] and c.
  - Its sum nibble is written to Sum[4k+3:4k].
  - Its carry-out is written to c.
  - k increments.
- Overflow is evaluated on the last nibble: Ovfl = (A_r[MSB] == B_r[MSB]) && (result[MSB] != A_r[MSB]). The final carry-out is not reported.
- The arithmetic wraps modulo 2^WIDTH unless ADD_SAT_EN is defined.
- start while in RUN is ignored: no queuing, and the operand latches are unchanged.
- sub, A and B are don't-care except in the cycle where start is accepted.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0
  - done = 0
  - Sum = 0
  - Ovfl = 0
  - k = 0
  - c = 0
- Latency:
  - start accepted at edge T.
  - busy is high from after edge T through edge T+N.
  - done is high for exactly one cycle, after edge T+N (16-bit: 4 RUN cycles, done visible 4 cycles after start is sampled).
- Throughput: back-to-back operation is allowed. start during the DONE cycle is accepted, giving one result every N+1 cycles.
- Sum and Ovfl are stable and valid from the done cycle until the RUN cycles of the next accepted operation.
- Partial Sum nibbles are visible during RUN and must not be consumed.
- rst asserted mid-operation returns all state to reset values immediately. No done is produced for the aborted operation.
- busy and done are never high in the same cycle.

## Configuration
- ADD_SAT_EN:
  - Defined: on the final nibble, if overflow is detected, Sum is replaced by the saturated value. Positive overflow gives 0x7FFF (generally 0 followed by WIDTH−1 ones). Negative overflow gives 0x8000. Ovfl is still set to 1.
  - Not defined: Sum is the wrapped result. Ovfl is reported identically.
  - Latency is identical in both builds.

## Structure
- Shared package wisc_alu_pkg holds:
  - The state enum typedef (IDLE, RUN, DONE).
  - NIBBLE_W = 4.
  - The saturation constant functions or localparams (SAT_POS, SAT_NEG) parameterised by width.
- One sub-module: a single fulladder_4bit instance as the nibble datapath. The operand mux, counter, carry register and FSM stay in this module.

## Test plan
- Add: A=0x1234, B=0x1111, sub=0, start for one cycle → busy for 4 cycles, single done pulse, Sum=0x2345, Ovfl=0.
- Positive overflow: A=0x7FFF, B=0x0001, sub=0 → Ovfl=1. Sum=0x8000 without ADD_SAT_EN, Sum=0x7FFF with it.
- Subtract with borrow across all nibbles: A=0x0000, B=0x0001, sub=1 → Sum=0xFFFF, Ovfl=0. Then A=0x8000, B=0x0001, sub=1 → Ovfl=1, Sum=0x7FFF (wrap) or 0x8000 (ADD_SAT_EN).
- Back-to-back and busy-ignore:
  - start held high continuously with A=0x0F0F, B=0x00F1 → done every 5 cycles, each Sum=0x1000.
  - A changed mid-RUN → result unaffected.
- Reset mid-operation: rst asserted during the 2nd RUN cycle of 0xFFFF+0x0001 → all outputs 0 immediately, no done. A following start of 0x0002+0x0003 → Sum=0x0005.
